maquina_estados_param: RTL and testbench
========================================

MAQUINA_ESTADOS_PARAM -- requirements
Module: maquina_estados_param

Interface
REQ-001 Parameter N_NEEDS, default 5, number of need channels (1..8).
REQ-002 Parameter W, default 3, width of each need value; MAXV = 2^W-1.
REQ-003 Parameter T_LOW, default 5, "low" threshold (need < T_LOW).
REQ-004 Parameter T_SICK, default 3, "sick" threshold (need < T_SICK).
REQ-005 Parameter N_SICK, default 3, minimum sick-need count that selects DESOLADA.
REQ-006 Parameter N_LOW, default 2, minimum low-need count that selects MUERTE.
REQ-007 Parameter PERSIST, default 4, consecutive equal-candidate ticks required before a non-bypass change (1..15).
REQ-008 clk  input  1  single clock; all state changes on its rising edge.
REQ-009 rst  input  1  reset, asynchronous and active-high.
REQ-010 tick  input  1  evaluation strobe, one-cycle pulse.
REQ-011 needs  input  N_NEEDS*W  packed need values; channel i at bits [i*W +: W]; legacy order 0 nutricion, 1 humedad, 2 podado, 3 mantenimiento, 4 energia.
REQ-012 reposando  input  1  rest request (level).
REQ-013 revive  input  1  clears latched death (one-cycle pulse).
REQ-014 estado  output  4  registered plant state.
REQ-015 carencia_idx  output  3  index of the lowest-numbered low need; 0 when no need is low.
REQ-016 muerta  output  1  death latch.
REQ-017 cambio  output  1  one-cycle pulse on every cycle in which estado takes a new value.

Function
REQ-018 State codes: BIEN 0, EXCELENTE 1, INSOLADO 2, DORMIDA 3, DESNUTRIDA 4, DESHIDRATADA 5, DESCUIDADA 6, REMONTADA 7, DESOLADA 8, MUERTE 9, CARENCIA_EXT 10; codes 11-15 never driven.
REQ-019 Candidate, combinational from needs, strict priority: sick count >= N_SICK -> DESOLADA; low count >= N_LOW -> MUERTE; any low need -> deficiency code of lowest low index; all needs == MAXV -> EXCELENTE; else BIEN.
REQ-020 Deficiency mapping: index 0->4, 1->5, 2->7, 3->6, 4->2, index >= 5 -> CARENCIA_EXT.
REQ-021 Low and sick counts are full-width, 4-bit sums, with no overflow for N_NEEDS <= 8.
REQ-022 Persistence is evaluated on tick only: if candidate equals pending, cnt increments and saturates at PERSIST; otherwise pending <= candidate and cnt <= 1.
REQ-023 When post-update cnt == PERSIST and estado != pending, estado <= pending on that same edge; with PERSIST=1 this is one-edge latency from tick.
REQ-024 reposando=1 (muerta=0) bypasses tick and persistence: estado <= DORMIDA on the next edge; pending and cnt are cleared to BIEN and 0 while reposando is held.
REQ-025 On reposando release, estado remains DORMIDA until the persistence rule commits a candidate.
REQ-026 Committing MUERTE sets muerta=1 on the same edge; while muerta=1, estado is held at MUERTE, and tick and reposando are ignored.
REQ-027 revive=1 sets estado <= BIEN, muerta <= 0, pending <= BIEN, and cnt <= 0 on the next edge, and has priority over reposando and tick in the same cycle.
REQ-028 revive while muerta=0 behaves identically (forced BIEN).
REQ-029 carencia_idx is registered and updated on every tick from the current needs, regardless of persistence; it holds otherwise.
REQ-030 cambio=1 for exactly the cycle after any edge where estado's value differed from its previous value; it is 0 when a commit rewrites the same value.

Reset
REQ-031 rst=1 asynchronously forces estado=BIEN, muerta=0, cambio=0, carencia_idx=0, pending=BIEN, cnt=0.
REQ-032 Outputs hold reset values while rst=1; evaluation resumes at the first tick after deassertion.
REQ-033 rst asserted mid-persistence discards the partial count.

Verification
REQ-034 Defaults, all needs=7, PERSIST ticks -> estado=1 (EXCELENTE) after 4th tick, cambio pulses once.
REQ-035 needs ch1=4, others=7, 3 ticks then ch1=7 on 4th -> estado stays BIEN; 4 ticks at ch1=4 -> estado=5, carencia_idx=1.
REQ-036 ch0=2,ch2=2,ch4=1 (3 sick) -> estado=8 after 4 ticks; then ch0=4,ch2=4 only (2 low) for 4 ticks -> estado=9, muerta=1; later reposando=1 -> estado stays 9.
REQ-037 muerta=1, revive and reposando same cycle -> next edge estado=0, muerta=0; following cycle reposando still 1 -> estado=3.
REQ-038 N_NEEDS=8, ch6=0 only low -> estado=10, carencia_idx=6; rst pulse mid-sequence -> estado=0 asynchronously, then 4 fresh ticks needed.

Source files
------------

// File: rtl/maquina_estados_param.sv
// Plant-state FSM: classifies need levels into a candidate, commits it after PERSIST agreeing ticks.
// Rest forces DORMIDA, a committed MUERTE latches until revive; cambio flags every estado change.
module maquina_estados_param #(
  parameter int N_NEEDS = 5,
  parameter int W       = 3,
  parameter int T_LOW   = 5,
  parameter int T_SICK  = 3,
  parameter int N_SICK  = 3,
  parameter int N_LOW   = 2,
  parameter int PERSIST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [N_NEEDS*W-1:0] needs,
  input  logic                 reposando,
  input  logic                 revive,
  output logic [3:0]           estado,
  output logic [2:0]           carencia_idx,
  output logic                 muerta,
  output logic                 cambio
);

  localparam logic [3:0] BIEN         = 4'd0;
  localparam logic [3:0] EXCELENTE    = 4'd1;
  localparam logic [3:0] INSOLADO     = 4'd2;
  localparam logic [3:0] DORMIDA      = 4'd3;
  localparam logic [3:0] DESNUTRIDA   = 4'd4;
  localparam logic [3:0] DESHIDRATADA = 4'd5;
  localparam logic [3:0] DESCUIDADA   = 4'd6;
  localparam logic [3:0] REMONTADA    = 4'd7;
  localparam logic [3:0] DESOLADA     = 4'd8;
  localparam logic [3:0] MUERTE       = 4'd9;
  localparam logic [3:0] CARENCIA_EXT = 4'd10;

  localparam logic [W-1:0] MAXV = '1;
  localparam logic [3:0]   PMAX = 4'(PERSIST);

  logic [3:0]   estado_q, estado_d;
  logic [3:0]   pend_q, pend_d;
  logic [3:0]   cnt_q, cnt_d, cnt_nx;
  logic [2:0]   idx_q, idx_d;
  logic         muerta_q, muerta_d;
  logic         cambio_q, cambio_d;

  logic [3:0]   low_cnt, sick_cnt, cand;
  logic [2:0]   low_idx;
  logic         any_low, all_max;
  logic [W-1:0] nv;

  function automatic logic [3:0] def_code(input logic [2:0] idx);
    case (idx)
      3'd0:    def_code = DESNUTRIDA;
      3'd1:    def_code = DESHIDRATADA;
      3'd2:    def_code = REMONTADA;
      3'd3:    def_code = DESCUIDADA;
      3'd4:    def_code = INSOLADO;
      default: def_code = CARENCIA_EXT;
    endcase
  endfunction

  // Descending scan so the last hit recorded is the lowest-numbered low need.
  always_comb begin
    low_cnt  = '0;
    sick_cnt = '0;
    low_idx  = '0;
    any_low  = 1'b0;
    all_max  = 1'b1;
    nv       = '0;
    for (int i = N_NEEDS - 1; i >= 0; i--) begin
      nv = needs[i*W +: W];
      if (32'(nv) < T_LOW) begin
        low_cnt += 4'd1;
        low_idx  = 3'(i);
        any_low  = 1'b1;
      end
      if (32'(nv) < T_SICK) sick_cnt += 4'd1;
      if (nv != MAXV) all_max = 1'b0;
    end
    cand = BIEN;
    if (32'(sick_cnt) >= N_SICK)    cand = DESOLADA;
    else if (32'(low_cnt) >= N_LOW) cand = MUERTE;
    else if (any_low)               cand = def_code(low_idx);
    else if (all_max)               cand = EXCELENTE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= BIEN;
      pend_q   <= BIEN;
      cnt_q    <= '0;
      idx_q    <= '0;
      muerta_q <= 1'b0;
      cambio_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      muerta_q <= muerta_d;
      cambio_q <= cambio_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    muerta_d = muerta_q;
    idx_d    = idx_q;
    cnt_nx   = '0;
    if (tick) idx_d = low_idx;
    if (revive) begin
      estado_d = BIEN;
      muerta_d = 1'b0;
      pend_d   = BIEN;
      cnt_d    = '0;
    end else if (!muerta_q) begin
      if (reposando) begin
        estado_d = DORMIDA;
        pend_d   = BIEN;
        cnt_d    = '0;
      end else if (tick) begin
        if (cand == pend_q) cnt_nx = (cnt_q >= PMAX) ? PMAX : cnt_q + 4'd1;
        else                cnt_nx = 4'd1;
        pend_d = cand;
        cnt_d  = cnt_nx;
        if (cnt_nx == PMAX && estado_q != cand) begin
          estado_d = cand;
          if (cand == MUERTE) muerta_d = 1'b1;
        end
      end
    end
    cambio_d = (estado_d != estado_q);
  end

  always_comb begin
    estado       = estado_q;
    carencia_idx = idx_q;
    muerta       = muerta_q;
    cambio       = cambio_q;
  end

endmodule

// File: tb/tb_maquina_estados_param.sv
// Self-checking bench: a 5-channel and an 8-channel instance share stimulus and are compared
// against a history-queue reference model after every clock edge.
module tb_maquina_estados_param;

  localparam int PERSIST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        rep = 1'b0;
  logic        rev = 1'b0;
  logic [23:0] needs8 = '1;
  logic [3:0]  est5, est8;
  logic [2:0]  idx5, idx8;
  logic        mu5, mu8, cb5, cb8;

  int n_tests = 0;
  int n_fail  = 0;
  int nd[8];
  int m_est[2], m_mu[2], m_idx[2], m_cb[2];
  int h0[$], h1[$];
  int def_map[8] = '{4, 5, 7, 6, 2, 10, 10, 10};

  always #5 clk = ~clk;

  maquina_estados_param dut5 (
    .clk(clk), .rst(rst), .tick(tick), .needs(needs8[14:0]), .reposando(rep), .revive(rev),
    .estado(est5), .carencia_idx(idx5), .muerta(mu5), .cambio(cb5)
  );

  maquina_estados_param #(.N_NEEDS(8)) dut8 (
    .clk(clk), .rst(rst), .tick(tick), .needs(needs8), .reposando(rep), .revive(rev),
    .estado(est8), .carencia_idx(idx8), .muerta(mu8), .cambio(cb8)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_needs();
    for (int i = 0; i < 8; i++) needs8[i*3 +: 3] = 3'(nd[i]);
  endtask

  function automatic int first_low(input int n);
    for (int i = 0; i < n; i++) if (nd[i] < 5) return i;
    return -1;
  endfunction

  function automatic int cand_of(input int n);
    int lo, si, allmax, f;
    lo = 0; si = 0; allmax = 1;
    for (int i = 0; i < n; i++) begin
      if (nd[i] < 5) lo++;
      if (nd[i] < 3) si++;
      if (nd[i] != 7) allmax = 0;
    end
    f = first_low(n);
    if (si >= 3) return 8;
    if (lo >= 2) return 9;
    if (f >= 0) return def_map[f];
    if (allmax == 1) return 1;
    return 0;
  endfunction

  task automatic clear_hist(input int k);
    if (k == 0) h0.delete();
    else        h1.delete();
  endtask

  // A candidate commits once the last PERSIST ticks since the last clear all agree on it.
  task automatic push_hist(input int k, input int c, output bit held);
    if (k == 0) begin
      h0.push_back(c);
      if (h0.size() > PERSIST) void'(h0.pop_front());
      held = (h0.size() == PERSIST);
      foreach (h0[j]) if (h0[j] != c) held = 1'b0;
    end else begin
      h1.push_back(c);
      if (h1.size() > PERSIST) void'(h1.pop_front());
      held = (h1.size() == PERSIST);
      foreach (h1[j]) if (h1[j] != c) held = 1'b0;
    end
  endtask

  task automatic model_edge(input int k, input int n);
    int prev, c, f;
    bit held;
    if (rst) begin
      m_est[k] = 0; m_mu[k] = 0; m_idx[k] = 0; m_cb[k] = 0;
      clear_hist(k);
    end else begin
      prev = m_est[k];
      if (tick) begin
        f = first_low(n);
        m_idx[k] = (f < 0) ? 0 : f;
      end
      if (rev) begin
        m_est[k] = 0; m_mu[k] = 0;
        clear_hist(k);
      end else if (m_mu[k] == 0) begin
        if (rep) begin
          m_est[k] = 3;
          clear_hist(k);
        end else if (tick) begin
          c = cand_of(n);
          push_hist(k, c, held);
          if (held && m_est[k] != c) begin
            m_est[k] = c;
            if (c == 9) m_mu[k] = 1;
          end
        end
      end
      m_cb[k] = (m_est[k] != prev) ? 1 : 0;
    end
  endtask

  task automatic check_all();
    check("estado5", int'(est5), m_est[0]);
    check("muerta5", int'(mu5),  m_mu[0]);
    check("cambio5", int'(cb5),  m_cb[0]);
    check("idx5",    int'(idx5), m_idx[0]);
    check("estado8", int'(est8), m_est[1]);
    check("muerta8", int'(mu8),  m_mu[1]);
    check("cambio8", int'(cb8),  m_cb[1]);
    check("idx8",    int'(idx8), m_idx[1]);
  endtask

  task automatic cycle(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    model_edge(0, 5);
    model_edge(1, 8);
    tick = 1'b0;
    check_all();
  endtask

  task automatic all_seven();
    for (int i = 0; i < 8; i++) nd[i] = 7;
    set_needs();
  endtask

  initial begin
    all_seven();
    cycle(1'b0);
    cycle(1'b1);
    rst = 1'b0;

    // All needs full: EXCELENTE after the fourth tick, single cambio pulse.
    for (int i = 0; i < PERSIST; i++) cycle(1'b1);
    check("req34_estado", int'(est5), 1);
    check("req34_cambio", int'(cb5), 1);
    cycle(1'b0);
    check("req34_cambio_drop", int'(cb5), 0);

    // Interrupted low-humidity run does not commit; a full run does.
    rev = 1'b1; cycle(1'b0); rev = 1'b0;
    nd[1] = 4; set_needs();
    for (int i = 0; i < 3; i++) cycle(1'b1);
    nd[1] = 7; set_needs();
    cycle(1'b1);
    check("req35_hold", int'(est5), 0);
    nd[1] = 4; set_needs();
    for (int i = 0; i < PERSIST; i++) cycle(1'b1);
    check("req35_estado", int'(est5), 5);
    check("req35_idx", int'(idx5), 1);

    // Three sick needs -> DESOLADA, then two low -> MUERTE latch that ignores rest.
    all_seven();
    nd[0] = 2; nd[2] = 2; nd[4] = 1; set_needs();
    for (int i = 0; i < PERSIST; i++) cycle(1'b1);
    check("req36_desolada", int'(est5), 8);
    nd[0] = 4; nd[2] = 4; nd[4] = 7; set_needs();
    for (int i = 0; i < PERSIST; i++) cycle(1'b1);
    check("req36_muerte", int'(est5), 9);
    check("req36_muerta", int'(mu5), 1);
    rep = 1'b1;
    cycle(1'b1);
    cycle(1'b0);
    check("req36_rest_ignored", int'(est5), 9);

    // Revive beats rest in the same cycle; held rest then forces DORMIDA.
    rev = 1'b1; cycle(1'b0); rev = 1'b0;
    check("req37_revive", int'(est5), 0);
    check("req37_muerta", int'(mu5), 0);
    cycle(1'b0);
    check("req37_dormida", int'(est5), 3);
    rep = 1'b0;

    // Eighth-channel-range deficiency, with an asynchronous reset mid-run.
    all_seven();
    nd[6] = 0; set_needs();
    cycle(1'b1);
    cycle(1'b1);
    rst = 1'b1;
    #2;
    model_edge(0, 5);
    model_edge(1, 8);
    check("req38_async_est8", int'(est8), 0);
    check("req38_async_est5", int'(est5), 0);
    check_all();
    cycle(1'b1);
    rst = 1'b0;
    for (int i = 0; i < PERSIST - 1; i++) cycle(1'b1);
    check("req38_fresh_hold", int'(est8), 0);
    cycle(1'b1);
    check("req38_estado", int'(est8), 10);
    check("req38_idx", int'(idx8), 6);

    // Randomized traffic, needs biased toward full so several states are visited.
    for (int r = 0; r < 600; r++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < 8; i++)
          nd[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 7;
        set_needs();
      end
      rep = ($urandom_range(0, 19) == 0);
      rev = (m_mu[0] == 1 || m_mu[1] == 1) ? ($urandom_range(0, 7) == 0)
                                          : ($urandom_range(0, 39) == 0);
      cycle(1'($urandom_range(0, 1)));
      rev = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
